// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a classic five-stage in-order core
// (IF, ID, EX, MEM, WB). It decides, every cycle and with zero latency, which
// stage must stall, flush or extend its occupancy:
//   * ID stall on a load-use dependency against the instruction in EX.
//   * ID flush when the branch in EX resolves taken.
//   * EX extension while the multi-cycle multiply/divide unit (MDU) runs.
//   * MEM extension while a memory access waits for the memory to respond.
// It also keeps a saturating count of consecutive memory wait cycles and a
// sticky timeout flag that is raised once that count pins at its maximum.
//
// Ports
//   clk              sole clock, all state changes on its rising edge
//   rst              synchronous, active-high reset
//   id_rs, id_rt     ID-stage source register numbers
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   id_dirty         ID slot holds a bubble
//   ex_rd            EX destination register
//   ex_mem_read      EX instruction is a load
//   ex_dirty         EX slot holds a bubble
//   ex_branch_taken  EX branch resolved taken
//   ex_mdu_start     EX instruction starts an MDU operation
//   ex_mdu_div       MDU operation select: 0 = multiply, 1 = divide
//   mem_req          MEM stage is issuing a memory access
//   mem_ready        memory accepts/completes the access this cycle
//   mem_dirty        MEM slot holds a bubble
//   stall/flush/extend  per-stage control, bit4=IF .. bit0=WB
//   busy             MDU FSM is not idle
//   mdu_done         one-cycle pulse when the MDU result leaves EX
//   mem_wait_cnt     saturating count of consecutive memory wait cycles
//   mem_timeout      sticky: wait count pinned at 255 while still waiting
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_dirty,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_dirty,
  input  logic       ex_branch_taken,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_div,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       mem_dirty,
  output logic [4:0] stall,
  output logic [4:0] flush,
  output logic [4:0] extend,
  output logic       busy,
  output logic       mdu_done,
  output logic [7:0] mem_wait_cnt,
  output logic       mem_timeout
);

  // Counter preload values. The start cycle itself already extends EX, so a
  // multiply occupies EX for 1 + 2 + 1 = 4 cycles and a divide for
  // 1 + 30 + 1 = 32 cycles when MEM is not waiting.
  localparam logic [4:0] MUL_CYC = 5'd2;
  localparam logic [4:0] DIV_CYC = 5'd30;

  typedef enum logic {
    IDLE = 1'b0,
    MDU  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] cnt;
  logic [4:0] cnt_nxt;

  logic       ex_valid;
  logic       mem_ext;
  logic       mdu_ext;
  logic       done_raw;
  logic       load_use;
  logic       flush_id;
  logic       stall_id;
  logic       pipe_held;

  // Saturating +1 for the 8-bit wait counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign ex_valid = ex_mdu_start & ~ex_dirty;

  // A bubble in MEM never waits on memory. Reset masks the output so the
  // pipeline sees no extension while the controller is being reset.
  assign mem_ext = ~rst & mem_req & ~mem_ready & ~mem_dirty;

  // MDU sequencing: next state, counter and the raw EX extension/done
  // strobes. The counter keeps running while MEM waits; only the final
  // hand-off out of EX has to wait for MEM to advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_ext   = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          mdu_ext   = 1'b1;
          cnt_nxt   = ex_mdu_div ? DIV_CYC : MUL_CYC;
          state_nxt = MDU;
        end
      end
      MDU: begin
        if (cnt != 5'd0) begin
          mdu_ext = 1'b1;
          cnt_nxt = cnt - 5'd1;
        end else if (!mem_ext) begin
          done_raw  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Load-use: a load in EX writes a register the ID instruction reads.
  // Register 0 is hard-wired, so it never creates a dependency.
  assign load_use = ex_mem_read & ~ex_dirty & ~id_dirty & (ex_rd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rd)) |
                     (id_uses_rt & (id_rt == ex_rd)));

  // While EX or MEM is extended nothing advances, so ID decisions are
  // deferred until the pipeline moves again. A taken branch squashes ID,
  // which makes any stall of that same instruction pointless.
  assign pipe_held = mdu_ext | mem_ext;
  assign flush_id  = ~rst & ~pipe_held & ex_branch_taken & ~ex_dirty;
  assign stall_id  = ~rst & ~pipe_held & load_use & ~flush_id;

  assign stall    = {1'b0, stall_id, 3'b000};
  assign flush    = {1'b0, flush_id, 3'b000};
  assign extend   = {2'b00, mdu_ext & ~rst, mem_ext, 1'b0};
  assign busy     = ~rst & (state == MDU);
  assign mdu_done = ~rst & done_raw;

  // State register: FSM, MDU counter, memory wait statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      mem_wait_cnt <= 8'd0;
      mem_timeout  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mem_ext) begin
        mem_wait_cnt <= sat_inc8(mem_wait_cnt);
      end else begin
        mem_wait_cnt <= 8'd0;
      end
      if (mem_ext && (mem_wait_cnt == 8'hFF)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Inputs change 1 time unit after the rising
// edge; combinational outputs are sampled a further time unit later, well
// before the next edge. Expected values are written out by hand per step.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_dirty;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_dirty;
  logic       ex_branch_taken;
  logic       ex_mdu_start;
  logic       ex_mdu_div;
  logic       mem_req;
  logic       mem_ready;
  logic       mem_dirty;
  logic [4:0] stall;
  logic [4:0] flush;
  logic [4:0] extend;
  logic       busy;
  logic       mdu_done;
  logic [7:0] mem_wait_cnt;
  logic       mem_timeout;

  int tests = 0;
  int fails = 0;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dirty        (id_dirty),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_dirty        (ex_dirty),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .ex_mdu_div      (ex_mdu_div),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .mem_dirty       (mem_dirty),
    .stall           (stall),
    .flush           (flush),
    .extend          (extend),
    .busy            (busy),
    .mdu_done        (mdu_done),
    .mem_wait_cnt    (mem_wait_cnt),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every hazard source active: all controls must stay low.
    rst = 1'b1;
    id_rs = 5'd5; id_rt = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b0; id_dirty = 1'b0;
    ex_rd = 5'd5; ex_mem_read = 1'b1; ex_dirty = 1'b0; ex_branch_taken = 1'b1;
    ex_mdu_start = 1'b1; ex_mdu_div = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0; mem_dirty = 1'b0;
    cyc(); #1;
    chk("rst_stall", stall, 5'b00000);
    chk("rst_flush", flush, 5'b00000);
    chk("rst_extend", extend, 5'b00000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", mdu_done, 1'b0);
    cyc(); #1;
    chk("rst_wait_cnt", mem_wait_cnt, 8'd0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("rst_busy2", busy, 1'b0);
    cyc();
    rst = 1'b0;
    id_rs = 5'd0; id_uses_rs = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; ex_mdu_div = 1'b0; mem_req = 1'b0;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_extend", extend, 5'b00000);

    // Load-use hazard variants.
    cyc();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; #1;
    chk("lu_rs_stall", stall, 5'b01000);
    chk("lu_rs_flush", flush, 5'b00000);
    ex_rd = 5'd0; id_rs = 5'd0; #1;
    chk("lu_rd0_stall", stall, 5'b00000);
    cyc();
    id_uses_rs = 1'b0; id_rs = 5'd5; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    chk("lu_rt_stall", stall, 5'b01000);
    id_dirty = 1'b1; #1;
    chk("lu_id_dirty", stall, 5'b00000);
    cyc();
    id_dirty = 1'b0; ex_dirty = 1'b1; #1;
    chk("lu_ex_dirty", stall, 5'b00000);
    ex_dirty = 1'b0; id_uses_rt = 1'b0; #1;
    chk("lu_no_use", stall, 5'b00000);

    // Branch beats load-use; a bubble in EX cannot flush.
    cyc();
    id_uses_rt = 1'b1; ex_branch_taken = 1'b1; #1;
    chk("prio_flush", flush, 5'b01000);
    chk("prio_stall", stall, 5'b00000);
    ex_dirty = 1'b1; #1;
    chk("br_dirty_flush", flush, 5'b00000);

    // MEM wait hides ID decisions; a bubble in MEM never waits.
    cyc();
    ex_dirty = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk("memw_extend", extend, 5'b00010);
    chk("memw_stall", stall, 5'b00000);
    ex_branch_taken = 1'b1; #1;
    chk("memw_flush", flush, 5'b00000);
    mem_dirty = 1'b1; ex_branch_taken = 1'b0; #1;
    chk("memdirty_extend", extend, 5'b00000);
    chk("memdirty_stall", stall, 5'b01000);
    cyc();
    mem_req = 1'b0; mem_dirty = 1'b0; ex_mem_read = 1'b0; id_uses_rt = 1'b0; #1;
    chk("memw_cnt_clear", mem_wait_cnt, 8'd0);

    // Multiply: extend[2] for cycles 0..2, done in cycle 3, idle in cycle 4.
    cyc();
    ex_mdu_start = 1'b1; ex_mdu_div = 1'b0; ex_dirty = 1'b1; #1;
    chk("mul_dirty_extend", extend, 5'b00000);
    ex_dirty = 1'b0; #1;
    chk("mul_c0_extend", extend, 5'b00100);
    chk("mul_c0_busy", busy, 1'b0);
    chk("mul_c0_done", mdu_done, 1'b0);
    cyc();
    ex_mdu_start = 1'b0; ex_branch_taken = 1'b1; #1;
    chk("mul_c1_extend", extend, 5'b00100);
    chk("mul_c1_busy", busy, 1'b1);
    chk("mul_c1_flush", flush, 5'b00000);
    cyc();
    ex_mdu_start = 1'b1; ex_branch_taken = 1'b0; #1;
    chk("mul_c2_extend", extend, 5'b00100);
    chk("mul_c2_busy", busy, 1'b1);
    cyc();
    ex_mdu_start = 1'b0; #1;
    chk("mul_c3_extend", extend, 5'b00000);
    chk("mul_c3_done", mdu_done, 1'b1);
    chk("mul_c3_busy", busy, 1'b1);
    cyc(); #1;
    chk("mul_c4_busy", busy, 1'b0);
    chk("mul_c4_done", mdu_done, 1'b0);
    chk("mul_c4_extend", extend, 5'b00000);

    // Divide while MEM waits 40 cycles (cycles 0..39), memory ready in cycle 40.
    cyc();
    ex_mdu_start = 1'b1; ex_mdu_div = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; #1;
    chk("div_c0_extend", extend, 5'b00110);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      ex_mdu_start = 1'b0; #1;
      chk("div_ext2_extend", extend, 5'b00110);
      chk("div_ext2_busy", busy, 1'b1);
    end
    for (int k = 31; k <= 39; k++) begin
      cyc(); #1;
      chk("div_hold_extend", extend, 5'b00010);
      chk("div_hold_done", mdu_done, 1'b0);
      chk("div_hold_busy", busy, 1'b1);
    end
    chk("div_c39_wait_cnt", mem_wait_cnt, 8'd39);
    cyc();
    mem_ready = 1'b1; #1;
    chk("div_c40_extend", extend, 5'b00000);
    chk("div_c40_done", mdu_done, 1'b1);
    chk("div_c40_wait_cnt", mem_wait_cnt, 8'd40);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0; ex_mdu_div = 1'b0; #1;
    chk("div_c41_busy", busy, 1'b0);
    chk("div_c41_done", mdu_done, 1'b0);
    chk("div_c41_wait_cnt", mem_wait_cnt, 8'd0);

    // Memory stuck for 300 cycles: counter pins at 255, timeout sticks.
    cyc();
    mem_req = 1'b1; #1;
    chk("sat_c0_cnt", mem_wait_cnt, 8'd0);
    for (int k = 1; k < 300; k++) begin
      cyc(); #1;
      chk("sat_cnt", mem_wait_cnt, (k < 255) ? k : 255);
      chk("sat_timeout", mem_timeout, (k >= 256) ? 1'b1 : 1'b0);
    end
    cyc();
    mem_ready = 1'b1; #1;
    chk("sat_release_cnt", mem_wait_cnt, 8'd255);
    chk("sat_release_timeout", mem_timeout, 1'b1);
    chk("sat_release_extend", extend, 5'b00000);
    cyc(); #1;
    chk("sat_clear_cnt", mem_wait_cnt, 8'd0);
    chk("sat_sticky", mem_timeout, 1'b1);
    mem_req = 1'b0; mem_ready = 1'b0;
    repeat (3) cyc();
    chk("sat_sticky_later", mem_timeout, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    chk("timeout_rst", mem_timeout, 1'b0);
    chk("timeout_rst_cnt", mem_wait_cnt, 8'd0);

    // Reset in cycle 21 of a divide (counter = 10): no completion pulse.
    cyc();
    ex_mdu_start = 1'b1; ex_mdu_div = 1'b1; #1;
    chk("rdiv_c0_extend", extend, 5'b00100);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      ex_mdu_start = 1'b0; #1;
      chk("rdiv_run_extend", extend, 5'b00100);
    end
    cyc();
    rst = 1'b1; #1;
    chk("rdiv_rst_extend", extend, 5'b00000);
    chk("rdiv_rst_busy", busy, 1'b0);
    chk("rdiv_rst_done", mdu_done, 1'b0);
    cyc();
    rst = 1'b0; #1;
    chk("rdiv_after_extend", extend, 5'b00000);
    chk("rdiv_after_busy", busy, 1'b0);
    chk("rdiv_after_done", mdu_done, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(); #1;
      chk("rdiv_quiet_done", mdu_done, 1'b0);
      chk("rdiv_quiet_busy", busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have id_rs, id_rt, input, 5 each, ID-stage source register numbers.
REQ-004 SHALL have id_uses_rs, id_uses_rt, id_dirty, input, 1 each, ID source-valid flags and ID bubble flag.
REQ-005 SHALL have ex_rd, input, 5, EX destination register; ex_mem_read, ex_dirty, ex_branch_taken, ex_mdu_start, input, 1 each.
REQ-006 SHALL have ex_mdu_div, input, 1, MDU op select: 0 = multiply, 1 = divide.
REQ-007 SHALL have mem_req, mem_ready, mem_dirty, input, 1 each, MEM access request, memory ready, MEM bubble flag.
REQ-008 SHALL have stall, flush, extend, output, 5 each, pipeline control with bit4=IF, bit3=ID, bit2=EX, bit1=MEM, bit0=WB.
REQ-009 SHALL have busy, output, 1, FSM not IDLE; mdu_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have mem_wait_cnt, output, 8, saturating count of memory wait cycles; mem_timeout, output, 1, sticky.

Function
REQ-011 SHALL implement FSM states IDLE and MDU with a 5-bit down-counter cnt.
REQ-012 SHALL define ex_valid = ex_mdu_start & ~ex_dirty.
REQ-013 SHALL, in IDLE with ex_valid, assert extend[2] the same cycle, load cnt = 2 (mult) or 30 (div), and go to MDU.
REQ-014 SHALL, in MDU with cnt != 0, assert extend[2] and decrement cnt every cycle, regardless of extend[1].
REQ-015 SHALL, in MDU with cnt == 0, hold extend[2] = 0, and go to IDLE while pulsing mdu_done only when extend[1] = 0; otherwise remain in MDU.
REQ-016 SHALL ignore ex_mdu_start while in MDU; EX occupancy: multiply 4 cycles, divide 32 cycles, with no MEM wait.
REQ-017 SHALL assert extend[1] combinationally = mem_req & ~mem_ready & ~mem_dirty.
REQ-018 SHALL increment mem_wait_cnt each cycle extend[1] = 1, saturating at 255, and clear it on the first cycle extend[1] = 0.
REQ-019 SHALL set mem_timeout when mem_wait_cnt = 255 and extend[1] = 1; it clears only on rst.
REQ-020 SHALL assert stall[3] on a load-use hazard, defined as ex_mem_read & ~ex_dirty & ~id_dirty & ex_rd != 0 & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
REQ-021 SHALL assert flush[3] = ex_branch_taken & ~ex_dirty.
REQ-022 SHALL give flush[3] priority over stall[3], forcing stall[3] = 0 whenever flush[3] = 1.
REQ-023 SHALL force stall[3] and flush[3] to 0 whenever extend[2] or extend[1] is asserted; they re-evaluate once the pipeline advances.
REQ-024 SHALL tie stall[4,2,1,0], flush[4,2,1,0] and extend[4,3,0] to 0.
REQ-025 SHALL make all outputs zero-latency functions of inputs plus current state, with no registered delay on stall, flush or extend.

Reset
REQ-026 SHALL, while rst = 1, drive stall, flush, extend, busy and mdu_done to 0.
REQ-027 SHALL, on rst, set state IDLE, cnt 0, mem_wait_cnt 0 and mem_timeout 0.
REQ-028 SHALL, on rst asserted mid-MDU, drop extend[2] immediately and resume in IDLE with no mdu_done pulse.

Verification
REQ-029 SHALL cover: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> stall=5'b01000; same with ex_rd=0 -> stall=0.
REQ-030 SHALL cover: load-use and ex_branch_taken=1 in the same cycle -> flush=5'b01000, stall=0.
REQ-031 SHALL cover: mult start, mem_ready=1 -> extend[2] high 3 cycles, then mdu_done pulse on 4th cycle, busy low on 5th.
REQ-032 SHALL cover: div start with mem_req=1, mem_ready=0 for 40 cycles -> extend[2] high 31 cycles, mdu_done only in the cycle mem_ready rises, mem_wait_cnt=40 before clearing.
REQ-033 SHALL cover: mem_ready held low 300 cycles -> mem_wait_cnt saturates at 255, mem_timeout=1 and stays 1 until rst.
REQ-034 SHALL cover: rst pulsed at cnt=10 of a divide -> next cycle state IDLE, extend=0, busy=0, mdu_done never pulses.
